// File: rtl/conv_mac_unit_pkg.sv
// Shared definitions for the SRC multiply-accumulate stage: FSM encoding,
// default widths and the rounding constant.
package conv_mac_unit_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_COEF_WIDTH  = 16;
    localparam int DEF_ACC_WIDTH   = 40;
    localparam int DEF_OUT_WIDTH   = 16;
    localparam int DEF_FRAC_SHIFT  = 15;
    localparam int DEF_RAM_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_OUT   = 2'd3
    } mac_state_e;

    // Half an LSB of the shifted result, i.e. round-half-up before the floor shift.
    function automatic logic [63:0] round_const(input int shift);
        return 64'(1) << (shift - 1);
    endfunction

endpackage

// File: rtl/mac_round_sat.sv
// Round (half-up), arithmetic shift and narrow the accumulator to the output width.
// MAC_SATURATE_EN selects clamping; otherwise the result wraps to the low bits.
module mac_round_sat
    import conv_mac_unit_pkg::*;
#(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] acc_in,
    output logic [OUT_WIDTH-1:0] res_out
);

    localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(round_const(FRAC_SHIFT));

    // One guard bit so the rounding add can never wrap the sign.
    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] shifted;

    assign sum     = $signed({acc_in[ACC_WIDTH-1], acc_in}) + RND;
    assign shifted = sum >>> FRAC_SHIFT;

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        (ACC_WIDTH+1)'((64'(1) << (OUT_WIDTH - 1)) - 64'(1));
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

    always_comb begin
        res_out = shifted[OUT_WIDTH-1:0];
        if (shifted > OUT_MAX) begin
            res_out = OUT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < OUT_MIN) begin
            res_out = OUT_MIN[OUT_WIDTH-1:0];
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^shifted[ACC_WIDTH:OUT_WIDTH];
    assign res_out   = shifted[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/conv_mac_unit.sv
// Polyphase MAC stage: aligns taps with RAM read data, accumulates products and
// presents one rounded sample per convolution over valid/ready (MAC_SATURATE_EN in mac_round_sat).
module conv_mac_unit
    import conv_mac_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COEF_WIDTH  = DEF_COEF_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int FRAC_SHIFT  = DEF_FRAC_SHIFT,
    parameter int RAM_LATENCY = DEF_RAM_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  tap,
    input  logic                  tap_last,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [COEF_WIDTH-1:0] coef_in,
    output logic                  mac_ready,
    output logic [OUT_WIDTH-1:0]  out_sample,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

    mac_state_e                   state_q, state_d;
    logic [RAM_LATENCY-1:0]       tap_dl_q, tap_dl_d;
    logic [RAM_LATENCY-1:0]       last_dl_q, last_dl_d;
    logic signed [PROD_WIDTH-1:0] prod_q, prod_d;
    logic                         p1_vld_q, p1_vld_d;
    logic                         p1_last_q, p1_last_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         p2_last_q, p2_last_d;
    logic [OUT_WIDTH-1:0]         out_sample_q, out_sample_d;
    logic                         out_valid_q, out_valid_d;
    logic                         overrun_q, overrun_d;
    logic [OUT_WIDTH-1:0]         rounded;
    logic                         accept;
    logic                         finalise;

    mac_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_SHIFT(FRAC_SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round_sat (
        .acc_in (acc_q),
        .res_out(rounded)
    );

    // Datapath: tap delay line, P1 product register, P2 accumulator.
    always_comb begin
        tap_dl_d[0]  = tap;
        last_dl_d[0] = tap & tap_last;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            tap_dl_d[i]  = tap_dl_q[i-1];
            last_dl_d[i] = last_dl_q[i-1];
        end

        p1_vld_d  = tap_dl_q[RAM_LATENCY-1];
        p1_last_d = last_dl_q[RAM_LATENCY-1];
        prod_d    = prod_q;
        if (p1_vld_d) begin
            prod_d = PROD_WIDTH'($signed(data_in)) * PROD_WIDTH'($signed(coef_in));
        end

        // A product landing on the clearing edge becomes the first accumulated term.
        acc_d = start ? '0 : acc_q;
        if (p1_vld_q) begin
            acc_d = acc_d + ACC_WIDTH'(prod_q);
        end
        p2_last_d = p1_last_q;
    end

    // Control FSM and output register.
    always_comb begin
        accept   = out_valid_q & out_ready;
        finalise = (state_q == ST_FLUSH) && p2_last_q && !start;

        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_ACCUM: if (p1_last_d) state_d = ST_FLUSH;
            ST_FLUSH: if (p2_last_q) state_d = ST_OUT;
            ST_OUT:   if (accept)    state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_ACCUM;
        end

        out_sample_d = out_sample_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;
        if (accept) begin
            out_valid_d = 1'b0;
        end
        if (finalise) begin
            out_sample_d = rounded;
            out_valid_d  = 1'b1;
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tap_dl_q     <= '0;
            last_dl_q    <= '0;
            prod_q       <= '0;
            p1_vld_q     <= 1'b0;
            p1_last_q    <= 1'b0;
            acc_q        <= '0;
            p2_last_q    <= 1'b0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_dl_q     <= tap_dl_d;
            last_dl_q    <= last_dl_d;
            prod_q       <= prod_d;
            p1_vld_q     <= p1_vld_d;
            p1_last_q    <= p1_last_d;
            acc_q        <= acc_d;
            p2_last_q    <= p2_last_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign mac_ready  = (state_q == ST_IDLE);
    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Directed bench for conv_mac_unit with default parameters; expected values hand-computed.
module tb_conv_mac_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        tap;
    logic        tap_last;
    logic [15:0] data_in;
    logic [15:0] coef_in;
    logic        mac_ready;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    conv_mac_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tap       (tap),
        .tap_last  (tap_last),
        .data_in   (data_in),
        .coef_in   (coef_in),
        .mac_ready (mac_ready),
        .out_sample(out_sample),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timed out");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drives start with the first tap, data one cycle behind each tap (RAM latency 1),
    // then checks out_valid is still at its prior value at t_last+3 and set at t_last+4.
    task automatic run_conv(input string tag, input int n, input logic [15:0] d,
                            input logic [15:0] c, input logic [15:0] exp_out,
                            input logic pre_valid, input logic [15:0] pre_out);
        for (int i = 0; i <= n; i++) begin
            start    = (i == 0);
            tap      = (i < n);
            tap_last = (i == n - 1);
            data_in  = (i > 0) ? d : 16'h0;
            coef_in  = (i > 0) ? c : 16'h0;
            step();
        end
        start   = 1'b0;
        data_in = 16'h0;
        coef_in = 16'h0;
        step();
        chk1({tag, "_lat_vld"}, out_valid, pre_valid);
        if (pre_valid) chk16({tag, "_kept"}, out_sample, pre_out);
        step();
        chk1({tag, "_vld"}, out_valid, 1'b1);
        chk16({tag, "_out"}, out_sample, exp_out);
    endtask

    logic [15:0] exp_four;

    initial begin
`ifdef MAC_SATURATE_EN
        exp_four = 16'h7FFF;
`else
        exp_four = 16'h8000;
`endif
        rst = 1'b1; start = 1'b0; tap = 1'b0; tap_last = 1'b0;
        data_in = 16'h0; coef_in = 16'h0; out_ready = 1'b0;
        step();
        step();
        chk16("rst_sample", out_sample, 16'h0);
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_ready", mac_ready, 1'b1);
        rst = 1'b0;
        step();

        run_conv("two_tap", 2, 16'h4000, 16'h4000, 16'h4000, 1'b0, 16'h0);
        chk1("two_tap_busy", mac_ready, 1'b0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk1("two_tap_acc_vld", out_valid, 1'b0);
        chk1("two_tap_acc_rdy", mac_ready, 1'b1);

        run_conv("four_tap", 4, 16'h4000, 16'h4000, exp_four, 1'b0, 16'h0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk1("four_tap_acc_vld", out_valid, 1'b0);

        run_conv("neg_round", 1, 16'h8000, 16'h7FFF, 16'h8001, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("bp_vld", out_valid, 1'b1);
            chk16("bp_out", out_sample, 16'h8001);
            chk1("bp_rdy", mac_ready, 1'b0);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk1("bp_rel_vld", out_valid, 1'b0);
        chk1("bp_rel_rdy", mac_ready, 1'b1);

        run_conv("pend", 1, 16'h4000, 16'h4000, 16'h2000, 1'b0, 16'h0);
        chk1("pend_ovr", overrun, 1'b0);
        run_conv("ovr", 1, 16'h2000, 16'h2000, 16'h0800, 1'b1, 16'h2000);
        chk1("ovr_flag", overrun, 1'b1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk1("ovr_acc_vld", out_valid, 1'b0);
        step(); step();
        chk1("ovr_sticky", overrun, 1'b1);
        chk16("ovr_hold_out", out_sample, 16'h0800);

        start = 1'b1; tap = 1'b1; data_in = 16'h4000; coef_in = 16'h4000;
        step();
        start = 1'b0;
        step();
        step();
        chk1("mid_busy", mac_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk16("arst_sample", out_sample, 16'h0);
        chk1("arst_valid", out_valid, 1'b0);
        chk1("arst_overrun", overrun, 1'b0);
        chk1("arst_ready", mac_ready, 1'b1);
        tap = 1'b0; data_in = 16'h0; coef_in = 16'h0;
        step();
        rst = 1'b0;
        step();
        run_conv("post_rst", 1, 16'h4000, 16'h4000, 16'h2000, 1'b0, 16'h0);
        chk1("post_rst_ovr", overrun, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_mac_unit.md
# conv_mac_unit

Multiply-accumulate stage of the sample rate converter datapath. It sits directly downstream of the RAM address driver. It consumes the data and coefficient words read from the sample and coefficient RAMs at the addresses the driver generates, and accumulates one polyphase convolution. It then rounds and saturates the sum and presents one output sample through a valid/ready handshake.

## Interface
- DATA_WIDTH, 16: signed sample word width.
- COEF_WIDTH, 16: signed coefficient word width.
- ACC_WIDTH, 40: accumulator width; must be ≥ DATA_WIDTH+COEF_WIDTH+4.
- OUT_WIDTH, 16: output sample width.
- FRAC_SHIFT, 15: right shift applied to the accumulator (coefficient fractional bits); must be ≥ 1.
- RAM_LATENCY, 1: read latency of both RAMs, in cycles (1..4).

Ports:
- clk  in  1: sole clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: single-cycle pulse; aligned with the driver's address load (a_init).
- tap  in  1: an address is presented this cycle; aligned with the driver's cnt.
- tap_last  in  1: qualifies tap; marks the final tap of the convolution.
- data_in  in  DATA_WIDTH: sample RAM read data, valid RAM_LATENCY cycles after tap.
- coef_in  in  COEF_WIDTH: coefficient RAM read data, same timing as data_in.
- mac_ready  out  1: high when a new start is accepted without overrun.
- out_sample  out  OUT_WIDTH: signed result.
- out_valid  out  1: out_sample is valid.
- out_ready  in  1: consumer accepts out_sample.
- overrun  out  1: sticky flag; a result was lost. Cleared by rst only.

## Operation
- tap and tap_last pass through an internal RAM_LATENCY-deep delay line, so they align with data_in and coef_in.
- Pipeline stages:
  - P1: registered signed product, DATA_WIDTH+COEF_WIDTH bits.
  - P2: the product is sign-extended to ACC_WIDTH and added to the accumulator.
- On start, the accumulator clears. If the first aligned tap arrives in the same cycle as the clear, it loads the product instead.
- Finalise: acc + 2^(FRAC_SHIFT-1), arithmetic shift right by FRAC_SHIFT, then conversion to OUT_WIDTH (see Configuration). The result loads into the out_sample register.
- FSM states and transitions:
  - IDLE → ACCUM on start.
  - ACCUM → FLUSH when a delayed tap_last enters P1.
  - FLUSH → OUT when that tap's accumulation completes.
  - OUT → IDLE on out_valid & out_ready.
- mac_ready = (state == IDLE).
- start outside IDLE aborts the current convolution: the accumulator clears and the FSM enters ACCUM. If out_valid is high and unaccepted at that moment, out_sample is kept and nothing is flagged.
- Overrun: a finalise occurring while out_valid=1 and out_ready=0 overwrites out_sample and sets overrun.
- A tap with no start since reset accumulates into the current accumulator. This is not an error.

## Timing
- Reset values: out_sample=0, out_valid=0, overrun=0, mac_ready=1, state IDLE, accumulator and delay lines 0.
- Latency: tap_last at cycle t → out_valid high at cycle t+RAM_LATENCY+3.
- out_valid stays high until the cycle after out_valid & out_ready. out_sample is stable while out_valid=1, except on overrun.
- A convolution of N taps at one tap per cycle occupies the block for N+RAM_LATENCY+3 cycles.
- Back-to-back operation: start is accepted in the cycle out_valid & out_ready is sampled.
- rst mid-convolution: all state clears immediately. In-flight taps are discarded.

## Configuration
- MAC_SATURATE_EN defined: results above 2^(OUT_WIDTH-1)-1 clamp to that value; results below -2^(OUT_WIDTH-1) clamp to that value.
- MAC_SATURATE_EN undefined: the shifted result is truncated to its low OUT_WIDTH bits (two's-complement wrap).

## Structure
- Shared package: FSM state encoding (IDLE, ACCUM, FLUSH, OUT), the default width constants, and the rounding-constant function.
- One sub-module: mac_round_sat. It performs the combinational rounding, shift, and saturation (or wrap), parameterised by ACC_WIDTH, FRAC_SHIFT, OUT_WIDTH and MAC_SATURATE_EN.

## Test plan
All scenarios use default parameters.
- Two taps, data 0x4000 and coef 0x4000 each → out_sample=0x4000, out_valid at t_last+4.
- Four taps of 0x4000×0x4000:
  - MAC_SATURATE_EN defined → out_sample 0x7FFF.
  - MAC_SATURATE_EN undefined → out_sample 0x8000.
- One tap, data 0x8000, coef 0x7FFF → out_sample=0x8001, confirming round-half-up and floor behaviour.
- Backpressure: out_ready held low 5 cycles after out_valid → out_valid and out_sample hold and mac_ready=0. Then out_ready=1 for one cycle → out_valid=0 and mac_ready=1 next cycle.
- Overrun: result pending with out_ready=0, then start plus a 1-tap convolution (0x2000×0x2000) completes → out_sample=0x0800 and overrun=1, held until rst.
- Assert rst asynchronously mid-ACCUM (between clock edges) → outputs return to reset values immediately. A following 1-tap convolution (0x4000×0x4000) yields 0x2000.
